// File: rtl/zap_wb_arbiter_if.sv
// zap_wb_arbiter_if
// Bundles the two cache-side Wishbone masters, the shared external bus and
// the grant vector seen by zap_wb_arbiter.
//   slave  : arbiter view (takes master requests, drives the shared bus)
//   master : environment view (caches, bus slave and observers)
interface zap_wb_arbiter_if;

   // Master 0 (instruction cache)
   logic        i_m0_wb_cyc;
   logic        i_m0_wb_stb;
   logic        i_m0_wb_wen;
   logic [3:0]  i_m0_wb_sel;
   logic [31:0] i_m0_wb_adr;
   logic [31:0] i_m0_wb_dat;
   logic [2:0]  i_m0_wb_cti;
   logic        o_m0_wb_ack;
   logic        o_m0_wb_err;
   logic [31:0] o_m0_wb_dat;

   // Master 1 (data cache)
   logic        i_m1_wb_cyc;
   logic        i_m1_wb_stb;
   logic        i_m1_wb_wen;
   logic [3:0]  i_m1_wb_sel;
   logic [31:0] i_m1_wb_adr;
   logic [31:0] i_m1_wb_dat;
   logic [2:0]  i_m1_wb_cti;
   logic        o_m1_wb_ack;
   logic        o_m1_wb_err;
   logic [31:0] o_m1_wb_dat;

   // Shared external bus
   logic        o_wb_cyc;
   logic        o_wb_stb;
   logic        o_wb_wen;
   logic [3:0]  o_wb_sel;
   logic [31:0] o_wb_adr;
   logic [31:0] o_wb_dat;
   logic [2:0]  o_wb_cti;
   logic [31:0] i_wb_dat;
   logic        i_wb_ack;

   // One-hot current owner, 00 when nobody holds the bus
   logic [1:0]  o_grant;

   modport slave (
      input  i_m0_wb_cyc, i_m0_wb_stb, i_m0_wb_wen, i_m0_wb_sel,
             i_m0_wb_adr, i_m0_wb_dat, i_m0_wb_cti,
      output o_m0_wb_ack, o_m0_wb_err, o_m0_wb_dat,
      input  i_m1_wb_cyc, i_m1_wb_stb, i_m1_wb_wen, i_m1_wb_sel,
             i_m1_wb_adr, i_m1_wb_dat, i_m1_wb_cti,
      output o_m1_wb_ack, o_m1_wb_err, o_m1_wb_dat,
      output o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_sel,
             o_wb_adr, o_wb_dat, o_wb_cti,
      input  i_wb_dat, i_wb_ack,
      output o_grant
   );

   modport master (
      output i_m0_wb_cyc, i_m0_wb_stb, i_m0_wb_wen, i_m0_wb_sel,
             i_m0_wb_adr, i_m0_wb_dat, i_m0_wb_cti,
      input  o_m0_wb_ack, o_m0_wb_err, o_m0_wb_dat,
      output i_m1_wb_cyc, i_m1_wb_stb, i_m1_wb_wen, i_m1_wb_sel,
             i_m1_wb_adr, i_m1_wb_dat, i_m1_wb_cti,
      input  o_m1_wb_ack, o_m1_wb_err, o_m1_wb_dat,
      input  o_wb_cyc, o_wb_stb, o_wb_wen, o_wb_sel,
             o_wb_adr, o_wb_dat, o_wb_cti,
      output i_wb_dat, i_wb_ack,
      input  o_grant
   );

endinterface

// File: rtl/zap_wb_arbiter.sv
// zap_wb_arbiter
// Two-master Wishbone arbiter (instruction cache = master 0, data cache =
// master 1) in front of one shared bus. A granted master keeps the bus until
// it drops cyc, so bursts are never split. A 16-bit watchdog aborts a
// transfer whose stb has waited TIMEOUT cycles (1..65535) without ack.
// Optional feature: define ZAP_WB_ARB_RR_EN for round-robin between
// simultaneous requests; otherwise master 1 wins ties (fixed priority).
module zap_wb_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             i_clk,
   input  logic             i_reset,   // asynchronous, active low
   zap_wb_arbiter_if.slave  bus
);

   localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT0  = 2'd1,
      ST_GNT1  = 2'd2,
      ST_ABORT = 2'd3
   } state_t;

   state_t      state_reg;
   logic [1:0]  grant_reg;
   logic [1:0]  err_reg;
   logic [15:0] tmo_cnt_reg;
   logic [15:0] tmo_cnt_next;
   logic        abort_owner_reg;   // master index that was aborted

`ifdef ZAP_WB_ARB_RR_EN
   logic        last_owner_reg;    // 1 = master 1 was granted last
`endif

   // Per-master request fields gathered into index-able arrays
   logic [1:0]  m_cyc;
   logic [1:0]  m_stb;
   logic [1:0]  m_wen;
   logic [3:0]  m_sel [2];
   logic [31:0] m_adr [2];
   logic [31:0] m_dat [2];
   logic [2:0]  m_cti [2];

   logic [1:0]  ack_vec;
   logic        granted;
   logic        owner;
   logic        owner_cyc;
   logic        abort_cyc;
   logic        req_any;
   logic        pick_m1;

   assign m_cyc    = {bus.i_m1_wb_cyc, bus.i_m0_wb_cyc};
   assign m_stb    = {bus.i_m1_wb_stb, bus.i_m0_wb_stb};
   assign m_wen    = {bus.i_m1_wb_wen, bus.i_m0_wb_wen};
   assign m_sel[0] = bus.i_m0_wb_sel;
   assign m_sel[1] = bus.i_m1_wb_sel;
   assign m_adr[0] = bus.i_m0_wb_adr;
   assign m_adr[1] = bus.i_m1_wb_adr;
   assign m_dat[0] = bus.i_m0_wb_dat;
   assign m_dat[1] = bus.i_m1_wb_dat;
   assign m_cti[0] = bus.i_m0_wb_cti;
   assign m_cti[1] = bus.i_m1_wb_cti;

   assign granted      = (state_reg == ST_GNT0) || (state_reg == ST_GNT1);
   assign owner        = (state_reg == ST_GNT1);
   assign owner_cyc    = m_cyc[owner];
   assign abort_cyc    = m_cyc[abort_owner_reg];
   assign req_any      = |m_cyc;
   assign tmo_cnt_next = tmo_cnt_reg + 16'd1;

   // Tie-break: round-robin away from the last owner, or master 1 always
`ifdef ZAP_WB_ARB_RR_EN
   assign pick_m1 = m_cyc[1] & (~m_cyc[0] | ~last_owner_reg);
`else
   assign pick_m1 = m_cyc[1];
`endif

   // Bus ack reaches a master only while that master holds the grant
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ack
         assign ack_vec[gi] = grant_reg[gi] & bus.i_wb_ack;
      end
   endgenerate

   assign bus.o_m0_wb_ack = ack_vec[0];
   assign bus.o_m1_wb_ack = ack_vec[1];
   assign bus.o_m0_wb_err = err_reg[0];
   assign bus.o_m1_wb_err = err_reg[1];
   assign bus.o_m0_wb_dat = bus.i_wb_dat;
   assign bus.o_m1_wb_dat = bus.i_wb_dat;
   assign bus.o_grant     = grant_reg;

   // Route the owner's request onto the bus; idle pattern otherwise
   always_comb begin
      bus.o_wb_cyc = 1'b0;
      bus.o_wb_stb = 1'b0;
      bus.o_wb_wen = 1'b0;
      bus.o_wb_sel = 4'h0;
      bus.o_wb_adr = 32'h0;
      bus.o_wb_dat = 32'h0;
      bus.o_wb_cti = 3'b111;
      if (granted) begin
         bus.o_wb_cyc = m_cyc[owner];
         bus.o_wb_stb = m_stb[owner];
         bus.o_wb_wen = m_wen[owner];
         bus.o_wb_sel = m_sel[owner];
         bus.o_wb_adr = m_adr[owner];
         bus.o_wb_dat = m_dat[owner];
         bus.o_wb_cti = m_cti[owner];
      end
   end

   // Arbitration FSM with watchdog counter, grant and error registers
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_reg       <= ST_IDLE;
         grant_reg       <= 2'b00;
         err_reg         <= 2'b00;
         tmo_cnt_reg     <= 16'd0;
         abort_owner_reg <= 1'b0;
`ifdef ZAP_WB_ARB_RR_EN
         last_owner_reg  <= 1'b1;
`endif
      end else begin
         err_reg <= 2'b00;
         case (state_reg)
            ST_IDLE: begin
               tmo_cnt_reg <= 16'd0;
               if (req_any) begin
                  if (pick_m1) begin
                     state_reg <= ST_GNT1;
                     grant_reg <= 2'b10;
                  end else begin
                     state_reg <= ST_GNT0;
                     grant_reg <= 2'b01;
                  end
`ifdef ZAP_WB_ARB_RR_EN
                  last_owner_reg <= pick_m1;
`endif
               end
            end

            ST_GNT0, ST_GNT1: begin
               if (!owner_cyc) begin
                  // Owner finished its cycle: release after this edge
                  state_reg   <= ST_IDLE;
                  grant_reg   <= 2'b00;
                  tmo_cnt_reg <= 16'd0;
               end else if (!m_stb[owner] || bus.i_wb_ack) begin
                  tmo_cnt_reg <= 16'd0;
               end else if (tmo_cnt_next == TIMEOUT_C) begin
                  // Slave never answered: flag the owner and park the bus
                  state_reg       <= ST_ABORT;
                  grant_reg       <= 2'b00;
                  err_reg[owner]  <= 1'b1;
                  abort_owner_reg <= owner;
                  tmo_cnt_reg     <= tmo_cnt_next;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_next;
               end
            end

            ST_ABORT: begin
               tmo_cnt_reg <= 16'd0;
               if (!abort_cyc) begin
                  state_reg <= ST_IDLE;
               end
            end

            default: begin
               state_reg   <= ST_IDLE;
               grant_reg   <= 2'b00;
               tmo_cnt_reg <= 16'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// tb_zap_wb_arbiter
// Directed bench for zap_wb_arbiter with TIMEOUT = 4. Expected values are
// hand-derived; round-robin expectations follow ZAP_WB_ARB_RR_EN.
module tb_zap_wb_arbiter;

   logic i_clk = 1'b0;
   logic i_reset;
   int   errors = 0;
   int   checks = 0;

   zap_wb_arbiter_if bus ();

   zap_wb_arbiter #(.TIMEOUT(4)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   always #5 i_clk = ~i_clk;

   // Advance to 2 time units after the next rising edge
   task automatic step();
      @(posedge i_clk);
      #2;
   endtask

   task automatic idle_all();
      bus.i_m0_wb_cyc = 1'b0; bus.i_m0_wb_stb = 1'b0; bus.i_m0_wb_wen = 1'b0;
      bus.i_m0_wb_sel = 4'h0; bus.i_m0_wb_adr = 32'h0; bus.i_m0_wb_dat = 32'h0;
      bus.i_m0_wb_cti = 3'b000;
      bus.i_m1_wb_cyc = 1'b0; bus.i_m1_wb_stb = 1'b0; bus.i_m1_wb_wen = 1'b0;
      bus.i_m1_wb_sel = 4'h0; bus.i_m1_wb_adr = 32'h0; bus.i_m1_wb_dat = 32'h0;
      bus.i_m1_wb_cti = 3'b000;
      bus.i_wb_ack = 1'b0;
      bus.i_wb_dat = 32'h0;
   endtask

   task automatic test_reset();
      i_reset = 1'b0;
      idle_all();
      bus.i_m0_wb_cyc = 1'b1;
      bus.i_m0_wb_stb = 1'b1;
      bus.i_m0_wb_adr = 32'h1234;
      bus.i_wb_ack    = 1'b1;
      bus.i_wb_dat    = 32'h5A5A1234;
      step();
      step();
      checks++; if (bus.o_grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b expected 00", bus.o_grant); end
      checks++; if (bus.o_wb_cyc !== 1'b0) begin errors++; $display("FAIL rst_cyc: got %b expected 0", bus.o_wb_cyc); end
      checks++; if (bus.o_wb_stb !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b expected 0", bus.o_wb_stb); end
      checks++; if (bus.o_wb_cti !== 3'b111) begin errors++; $display("FAIL rst_cti: got %b expected 111", bus.o_wb_cti); end
      checks++; if (bus.o_wb_adr !== 32'h0) begin errors++; $display("FAIL rst_adr: got %h expected 0", bus.o_wb_adr); end
      checks++; if (bus.o_m0_wb_ack !== 1'b0) begin errors++; $display("FAIL rst_ack0: got %b expected 0", bus.o_m0_wb_ack); end
      checks++; if (bus.o_m1_wb_ack !== 1'b0) begin errors++; $display("FAIL rst_ack1: got %b expected 0", bus.o_m1_wb_ack); end
      checks++; if ({bus.o_m1_wb_err, bus.o_m0_wb_err} !== 2'b00) begin errors++; $display("FAIL rst_err: got %b expected 00", {bus.o_m1_wb_err, bus.o_m0_wb_err}); end
      checks++; if (bus.o_m1_wb_dat !== 32'h5A5A1234) begin errors++; $display("FAIL rst_dat1: got %h expected 5a5a1234", bus.o_m1_wb_dat); end
      idle_all();
      i_reset = 1'b1;
      step();
      $display("test_reset done");
   endtask

   task automatic test_single_read();
      bus.i_m0_wb_cyc = 1'b1; bus.i_m0_wb_stb = 1'b1; bus.i_m0_wb_sel = 4'hF;
      bus.i_m0_wb_adr = 32'h100; bus.i_m0_wb_cti = 3'b000;
      #1;
      checks++; if (bus.o_wb_cyc !== 1'b0) begin errors++; $display("FAIL sr_early_cyc: got %b expected 0", bus.o_wb_cyc); end
      step();
      checks++; if (bus.o_grant !== 2'b01) begin errors++; $display("FAIL sr_grant: got %b expected 01", bus.o_grant); end
      checks++; if (bus.o_wb_adr !== 32'h100) begin errors++; $display("FAIL sr_adr: got %h expected 100", bus.o_wb_adr); end
      checks++; if (bus.o_wb_cyc !== 1'b1 || bus.o_wb_stb !== 1'b1) begin errors++; $display("FAIL sr_cycstb: got %b%b expected 11", bus.o_wb_cyc, bus.o_wb_stb); end
      checks++; if (bus.o_m0_wb_ack !== 1'b0) begin errors++; $display("FAIL sr_noack: got %b expected 0", bus.o_m0_wb_ack); end
      step();
      bus.i_wb_ack = 1'b1; bus.i_wb_dat = 32'hCAFEF00D;
      #1;
      checks++; if (bus.o_m0_wb_ack !== 1'b1) begin errors++; $display("FAIL sr_ack0: got %b expected 1", bus.o_m0_wb_ack); end
      checks++; if (bus.o_m1_wb_ack !== 1'b0) begin errors++; $display("FAIL sr_ack1: got %b expected 0", bus.o_m1_wb_ack); end
      checks++; if (bus.o_m0_wb_dat !== 32'hCAFEF00D) begin errors++; $display("FAIL sr_dat0: got %h expected cafef00d", bus.o_m0_wb_dat); end
      step();
      idle_all();
      #1;
      checks++; if (bus.o_m0_wb_ack !== 1'b0) begin errors++; $display("FAIL sr_ack_pulse: got %b expected 0", bus.o_m0_wb_ack); end
      checks++; if (bus.o_wb_cyc !== 1'b0) begin errors++; $display("FAIL sr_drop_cyc: got %b expected 0", bus.o_wb_cyc); end
      step();
      checks++; if (bus.o_grant !== 2'b00) begin errors++; $display("FAIL sr_release: got %b expected 00", bus.o_grant); end
      $display("test_single_read done");
   endtask

   task automatic test_arbitration();
      logic [1:0]  exp_g;
      logic [31:0] exp_adr;
      i_reset = 1'b0;
      step();
      i_reset = 1'b1;
      step();
      for (int r = 0; r < 4; r++) begin
`ifdef ZAP_WB_ARB_RR_EN
         exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
`else
         exp_g = 2'b10;
`endif
         exp_adr = (exp_g == 2'b01) ? 32'hA0 + 32'(r) : 32'hB0 + 32'(r);
         bus.i_m0_wb_cyc = 1'b1; bus.i_m0_wb_stb = 1'b1; bus.i_m0_wb_adr = 32'hA0 + 32'(r);
         bus.i_m0_wb_wen = 1'b0; bus.i_m0_wb_sel = 4'hF;
         bus.i_m1_wb_cyc = 1'b1; bus.i_m1_wb_stb = 1'b1; bus.i_m1_wb_adr = 32'hB0 + 32'(r);
         bus.i_m1_wb_wen = 1'b1; bus.i_m1_wb_sel = 4'h3; bus.i_m1_wb_dat = 32'h11112222;
         step();
         checks++; if (bus.o_grant !== exp_g) begin errors++; $display("FAIL arb_grant[%0d]: got %b expected %b", r, bus.o_grant, exp_g); end
         checks++; if (bus.o_wb_adr !== exp_adr) begin errors++; $display("FAIL arb_adr[%0d]: got %h expected %h", r, bus.o_wb_adr, exp_adr); end
         checks++; if (bus.o_wb_wen !== exp_g[1]) begin errors++; $display("FAIL arb_wen[%0d]: got %b expected %b", r, bus.o_wb_wen, exp_g[1]); end
         checks++; if (bus.o_wb_sel !== (exp_g[1] ? 4'h3 : 4'hF)) begin errors++; $display("FAIL arb_sel[%0d]: got %h", r, bus.o_wb_sel); end
         bus.i_wb_ack = 1'b1;
         #1;
         checks++; if ({bus.o_m1_wb_ack, bus.o_m0_wb_ack} !== exp_g) begin errors++; $display("FAIL arb_ack[%0d]: got %b expected %b", r, {bus.o_m1_wb_ack, bus.o_m0_wb_ack}, exp_g); end
         step();
         idle_all();
         step();
         checks++; if (bus.o_grant !== 2'b00) begin errors++; $display("FAIL arb_idle[%0d]: got %b expected 00", r, bus.o_grant); end
         $display("arbitration round %0d: grant=%b", r, exp_g);
      end
   endtask

   task automatic test_burst();
      logic [2:0] exp_cti;
      idle_all();
      bus.i_m0_wb_cyc = 1'b1; bus.i_m0_wb_stb = 1'b1; bus.i_m0_wb_sel = 4'hF;
      bus.i_m0_wb_adr = 32'h200; bus.i_m0_wb_cti = 3'b010;
      step();
      for (int k = 0; k < 8; k++) begin
         exp_cti = (k == 7) ? 3'b111 : 3'b010;
         bus.i_m0_wb_adr = 32'h200 + 32'(4 * k);
         bus.i_m0_wb_cti = exp_cti;
         bus.i_wb_ack    = 1'b1;
         if (k == 3) begin
            bus.i_m1_wb_cyc = 1'b1; bus.i_m1_wb_stb = 1'b1; bus.i_m1_wb_adr = 32'h300;
         end
         #1;
         checks++; if (bus.o_grant !== 2'b01) begin errors++; $display("FAIL burst_grant[%0d]: got %b expected 01", k, bus.o_grant); end
         checks++; if (bus.o_wb_adr !== 32'h200 + 32'(4 * k)) begin errors++; $display("FAIL burst_adr[%0d]: got %h", k, bus.o_wb_adr); end
         checks++; if (bus.o_wb_cti !== exp_cti) begin errors++; $display("FAIL burst_cti[%0d]: got %b expected %b", k, bus.o_wb_cti, exp_cti); end
         checks++; if ({bus.o_m1_wb_ack, bus.o_m0_wb_ack} !== 2'b01) begin errors++; $display("FAIL burst_ack[%0d]: got %b expected 01", k, {bus.o_m1_wb_ack, bus.o_m0_wb_ack}); end
         $display("burst beat %0d adr=%h cti=%b", k, bus.o_wb_adr, bus.o_wb_cti);
         step();
      end
      bus.i_m0_wb_cyc = 1'b0; bus.i_m0_wb_stb = 1'b0; bus.i_wb_ack = 1'b0;
      #1;
      checks++; if (bus.o_grant !== 2'b01) begin errors++; $display("FAIL burst_hold: got %b expected 01", bus.o_grant); end
      step();
      checks++; if (bus.o_grant !== 2'b00) begin errors++; $display("FAIL burst_gap: got %b expected 00", bus.o_grant); end
      step();
      checks++; if (bus.o_grant !== 2'b10) begin errors++; $display("FAIL burst_m1_grant: got %b expected 10", bus.o_grant); end
      checks++; if (bus.o_wb_adr !== 32'h300) begin errors++; $display("FAIL burst_m1_adr: got %h expected 300", bus.o_wb_adr); end
      idle_all();
      step();
      step();
   endtask

   task automatic test_timeout();
      idle_all();
      bus.i_m1_wb_cyc = 1'b1; bus.i_m1_wb_stb = 1'b1; bus.i_m1_wb_adr = 32'h400;
      step();
      checks++; if (bus.o_grant !== 2'b10) begin errors++; $display("FAIL to_grant: got %b expected 10", bus.o_grant); end
      for (int i = 1; i < 4; i++) begin
         step();
         checks++; if (bus.o_m1_wb_err !== 1'b0 || bus.o_wb_stb !== 1'b1) begin errors++; $display("FAIL to_wait[%0d]: err=%b stb=%b expected 0 1", i, bus.o_m1_wb_err, bus.o_wb_stb); end
      end
      step();
      checks++; if (bus.o_m1_wb_err !== 1'b1) begin errors++; $display("FAIL to_err1: got %b expected 1", bus.o_m1_wb_err); end
      checks++; if (bus.o_m0_wb_err !== 1'b0) begin errors++; $display("FAIL to_err0: got %b expected 0", bus.o_m0_wb_err); end
      checks++; if (bus.o_grant !== 2'b00) begin errors++; $display("FAIL to_abort_grant: got %b expected 00", bus.o_grant); end
      checks++; if ({bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_cti} !== 5'b00111) begin errors++; $display("FAIL to_bus_idle: got %b expected 00111", {bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_cti}); end
      bus.i_wb_ack = 1'b1;
      #1;
      checks++; if (bus.o_m1_wb_ack !== 1'b0) begin errors++; $display("FAIL to_stray_ack: got %b expected 0", bus.o_m1_wb_ack); end
      bus.i_wb_ack = 1'b0;
      bus.i_m0_wb_cyc = 1'b1; bus.i_m0_wb_stb = 1'b1;
      step();
      checks++; if (bus.o_m1_wb_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse: got %b expected 0", bus.o_m1_wb_err); end
      step();
      checks++; if (bus.o_grant !== 2'b00) begin errors++; $display("FAIL to_abort_hold: got %b expected 00", bus.o_grant); end
      bus.i_m1_wb_cyc = 1'b0; bus.i_m1_wb_stb = 1'b0;
      step();
      checks++; if (bus.o_grant !== 2'b00) begin errors++; $display("FAIL to_idle: got %b expected 00", bus.o_grant); end
      step();
      checks++; if (bus.o_grant !== 2'b01) begin errors++; $display("FAIL to_resume: got %b expected 01", bus.o_grant); end
      idle_all();
      step();
      step();
      $display("test_timeout done");
   endtask

   task automatic test_reset_mid_burst();
      idle_all();
      bus.i_m0_wb_cyc = 1'b1; bus.i_m0_wb_stb = 1'b1; bus.i_m0_wb_cti = 3'b010;
      bus.i_m0_wb_adr = 32'h500;
      step();
      bus.i_wb_ack = 1'b1;
      step();
      bus.i_wb_ack = 1'b0;
      i_reset = 1'b0;
      #1;
      checks++; if ({bus.o_wb_cyc, bus.o_wb_stb} !== 2'b00) begin errors++; $display("FAIL mr_drop: got %b expected 00", {bus.o_wb_cyc, bus.o_wb_stb}); end
      checks++; if (bus.o_grant !== 2'b00) begin errors++; $display("FAIL mr_grant: got %b expected 00", bus.o_grant); end
      bus.i_wb_ack = 1'b1;
      #1;
      checks++; if (bus.o_m0_wb_ack !== 1'b0) begin errors++; $display("FAIL mr_stray_ack: got %b expected 0", bus.o_m0_wb_ack); end
      step();
      checks++; if (bus.o_m0_wb_ack !== 1'b0 || bus.o_wb_cyc !== 1'b0) begin errors++; $display("FAIL mr_hold: ack=%b cyc=%b expected 0 0", bus.o_m0_wb_ack, bus.o_wb_cyc); end
      bus.i_wb_ack = 1'b0;
      i_reset = 1'b1;
      step();
      checks++; if (bus.o_grant !== 2'b01 || bus.o_wb_cyc !== 1'b1) begin errors++; $display("FAIL mr_resume: grant=%b cyc=%b expected 01 1", bus.o_grant, bus.o_wb_cyc); end
      idle_all();
      step();
      step();
      $display("test_reset_mid_burst done");
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_arbitration();
      test_burst();
      test_timeout();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
